clock_time_keeper: RTL and testbench

Time-of-day core for the digital clock. It divides the 100 kHz system clock into a 1 Hz tick and keeps hours, minutes and seconds as BCD digits. It debounces the two front-panel buttons and runs the four-state mode machine. It sits directly upstream of the LED scan/output stage, which consumes its `digits` array and `mode_flag` unchanged.

---
 rtl/clock_time_keeper.sv | 142 ++++++++++++++
 tb/tb_clock_time_keeper.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_keeper.sv
// Time-of-day core: 1 Hz prescaler, BCD hh:mm:ss counter, two debounced
// front-panel buttons and the NORMAL/SET_SEC/SET_MIN/SET_HOUR mode machine.
module clock_time_keeper #(
  parameter int TICK_CYCLES     = 100000,
  parameter int DEBOUNCE_CYCLES = 2000
) (
  input  logic       clk100khz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [3:0] digits [6],
  output logic [1:0] mode_flag
);

  typedef enum logic [1:0] {
    NORMAL   = 2'd0,
    SET_SEC  = 2'd1,
    SET_MIN  = 2'd2,
    SET_HOUR = 2'd3
  } mode_t;

  localparam int PRE_W = $clog2(TICK_CYCLES + 1);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

  mode_t            mode;
  logic [PRE_W-1:0] pre;
  logic [1:0]       btn_raw;
  logic [1:0]       sync1, sync2, stable, stable_q, press;
  logic [DB_W-1:0]  db_cnt [2];
  logic             mode_press, inc_press, tick;
  logic             sec_wrap, min_wrap;
  logic [7:0]       sec_next, min_next, hour_next;

  // 59 -> 00 for a two-digit BCD pair whose tens digit tops out at 5.
  function automatic logic [7:0] inc_sixty(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd5 && u == 4'd9) return 8'h00;
    else if (u == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, u + 4'd1};
  endfunction

  function automatic logic [7:0] inc_hour(input logic [3:0] t, input logic [3:0] u);
    if (t == 4'd2 && u == 4'd3) return 8'h00;
    else if (u == 4'd9)         return {t + 4'd1, 4'd0};
    else                        return {t, u + 4'd1};
  endfunction

  assign btn_raw    = {btn_inc, btn_mode};
  assign mode_press = press[0];
  assign inc_press  = press[1];
  assign mode_flag  = mode;

  // A mode press on the terminal count swallows that tick.
  assign tick = (mode == NORMAL) && (pre == PRE_W'(TICK_CYCLES - 1)) && !mode_press;

  always_comb begin
    sec_next  = inc_sixty(digits[4], digits[5]);
    min_next  = inc_sixty(digits[2], digits[3]);
    hour_next = inc_hour(digits[0], digits[1]);
    sec_wrap  = (digits[4] == 4'd5) && (digits[5] == 4'd9);
    min_wrap  = (digits[2] == 4'd5) && (digits[3] == 4'd9);
  end

  always_ff @(posedge clk100khz or posedge rst) begin
    if (rst) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      press    <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= btn_raw;
      sync2    <= sync1;
      stable_q <= stable;
      press    <= stable & ~stable_q;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] != stable[i]) begin
          if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            stable[i] <= ~stable[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk100khz or posedge rst) begin
    if (rst) begin
      mode <= NORMAL;
      pre  <= '0;
      for (int i = 0; i < 6; i++) digits[i] <= '0;
    end else begin
      if (mode_press) begin
        pre <= '0;
        case (mode)
          NORMAL:   mode <= SET_SEC;
          SET_SEC:  mode <= SET_MIN;
          SET_MIN:  mode <= SET_HOUR;
          SET_HOUR: mode <= NORMAL;
        endcase
      end else if (mode == NORMAL) begin
        pre <= (pre == PRE_W'(TICK_CYCLES - 1)) ? '0 : pre + 1'b1;
      end else begin
        pre <= '0;
      end

      if (tick) begin
        digits[4] <= sec_next[7:4];
        digits[5] <= sec_next[3:0];
        if (sec_wrap) begin
          digits[2] <= min_next[7:4];
          digits[3] <= min_next[3:0];
          if (min_wrap) begin
            digits[0] <= hour_next[7:4];
            digits[1] <= hour_next[3:0];
          end
        end
      end else if (inc_press && !mode_press) begin
        case (mode)
          SET_SEC: begin
            digits[4] <= sec_next[7:4];
            digits[5] <= sec_next[3:0];
          end
          SET_MIN: begin
            digits[2] <= min_next[7:4];
            digits[3] <= min_next[3:0];
          end
          SET_HOUR: begin
            digits[0] <= hour_next[7:4];
            digits[1] <= hour_next[3:0];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock_time_keeper.sv
// Bench for clock_time_keeper: decimal reference model stepped edge by edge,
// expected {mode_flag, digits} pushed to a queue and compared against the DUT.
module tb_clock_time_keeper;

  localparam int TICK = 10;
  localparam int DB   = 4;
  localparam int W    = 26;

  logic       clk100khz = 1'b0;
  logic       rst       = 1'b1;
  logic       btn_mode  = 1'b0;
  logic       btn_inc   = 1'b0;
  logic [3:0] digits [6];
  logic [1:0] mode_flag;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  int m_h, m_m, m_s, m_mode, m_pre;

  clock_time_keeper #(.TICK_CYCLES(TICK), .DEBOUNCE_CYCLES(DB)) dut (
    .clk100khz (clk100khz),
    .rst       (rst),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .digits    (digits),
    .mode_flag (mode_flag)
  );

  // clock / reset
  always #5 clk100khz = ~clk100khz;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got mode=%0d time=%h, expected mode=%0d time=%h",
               tag, obs[25:24], obs[23:0], exp[25:24], exp[23:0]);
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    return {2'(m_mode), 4'(m_h / 10), 4'(m_h % 10), 4'(m_m / 10), 4'(m_m % 10),
            4'(m_s / 10), 4'(m_s % 10)};
  endfunction

  function automatic logic [W-1:0] dut_pack();
    return {mode_flag, digits[0], digits[1], digits[2], digits[3], digits[4], digits[5]};
  endfunction

  task automatic model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_mode = 0; m_pre = 0;
  endtask

  task automatic model_tick();
    m_s++;
    if (m_s == 60) begin
      m_s = 0;
      m_m++;
      if (m_m == 60) begin
        m_m = 0;
        m_h = (m_h + 1) % 24;
      end
    end
  endtask

  // ev: 0 = nothing, 1 = mode press takes effect, 2 = inc press takes effect
  task automatic model_edge(input int ev);
    if (ev == 1) begin
      m_mode = (m_mode + 1) % 4;
      m_pre  = 0;
    end else if (m_mode == 0) begin
      if (m_pre == TICK - 1) begin
        m_pre = 0;
        model_tick();
      end else begin
        m_pre++;
      end
    end else begin
      m_pre = 0;
      if (ev == 2) begin
        case (m_mode)
          1: m_s = (m_s + 1) % 60;
          2: m_m = (m_m + 1) % 60;
          default: m_h = (m_h + 1) % 24;
        endcase
      end
    end
  endtask

  task automatic step(input int ev);
    @(posedge clk100khz);
    model_edge(ev);
    #1;
  endtask

  // scoreboard: push the model's prediction, pop it against the DUT
  task automatic expect_now(input string tag);
    exp_q.push_back(model_pack());
    check(tag, dut_pack(), exp_q.pop_front());
  endtask

  // driver: hold the button(s) 'hold' edges, then release and let it settle
  task automatic press(input bit do_mode, input bit do_inc, input int hold);
    btn_mode = do_mode;
    btn_inc  = do_inc;
    for (int i = 1; i <= hold; i++) begin
      step((i == DB + 4) ? (do_mode ? 1 : 2) : 0);
      if (i == DB + 3) expect_now("press_before_effect");
      if (i == DB + 4) expect_now("press_effect");
    end
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    for (int i = 0; i < DB + 4; i++) step(0);
    expect_now("press_settled");
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1 model_reset();
    expect_now("async_reset");
    check("async_reset_zero", dut_pack(), '0);
    repeat (2) @(posedge clk100khz);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1 model_reset();
    expect_now("reset_state");
    repeat (2) @(posedge clk100khz);
    #1 rst = 1'b0;

    // free run 600 ticks
    repeat (5999) step(0);
    expect_now("run_5999");
    step(0);
    expect_now("run_6000");
    check("run_6000_const", dut_pack(), {2'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0});

    // mode cycling, hold in SET_SEC, prescaler restart on re-entry
    press(1, 0, DB + 4);
    check("mode_1", {24'd0, mode_flag}, 26'd1);
    repeat (100) step(0);
    expect_now("set_sec_frozen");
    press(1, 0, DB + 4);
    check("mode_2", {24'd0, mode_flag}, 26'd2);
    press(1, 0, DB + 4);
    check("mode_3", {24'd0, mode_flag}, 26'd3);
    press(1, 0, DB + 4);
    check("mode_0", {24'd0, mode_flag}, 26'd0);
    step(0);
    expect_now("reentry_no_tick");
    step(0);
    expect_now("reentry_first_tick");

    // hour wrap in SET_HOUR
    do_reset();
    for (int i = 0; i < 3; i++) press(1, 0, DB + 4);
    for (int n = 0; n < 30 && m_h != 23; n++) press(0, 1, DB + 4);
    expect_now("hour_23");
    press(0, 1, DB + 4);
    check("hour_wrap_const", dut_pack(), {2'd3, 24'h000000});
    for (int n = 0; n < 30 && m_h != 23; n++) press(0, 1, DB + 4);

    // seconds and minutes, minute wrap leaves hours alone
    press(1, 0, DB + 4);
    press(1, 0, DB + 4);
    for (int n = 0; n < 70 && m_s != 59; n++) press(0, 1, DB + 4);
    press(1, 0, DB + 4);
    for (int n = 0; n < 70 && m_m != 59; n++) press(0, 1, DB + 4);
    expect_now("min_59");
    press(0, 1, DB + 4);
    check("min_wrap_const", dut_pack(), {2'd2, 24'h230059});
    for (int n = 0; n < 70 && m_m != 59; n++) press(0, 1, DB + 4);
    check("preload_const", dut_pack(), {2'd2, 24'h235959});

    // back to NORMAL and roll over midnight
    press(1, 0, DB + 4);
    press(1, 0, DB + 4);
    step(0);
    check("pre_rollover_const", dut_pack(), {2'd0, 24'h235959});
    step(0);
    expect_now("rollover");
    check("rollover_const", dut_pack(), {2'd0, 24'h000000});

    // chatter then a held press in SET_SEC
    press(1, 0, DB + 4);
    for (int i = 0; i < 8; i++) begin
      btn_inc = 1'b1;
      repeat (3) step(0);
      btn_inc = 1'b0;
      repeat (3) step(0);
    end
    repeat (2) step(0);
    expect_now("chatter_none");
    press(0, 1, 20);
    expect_now("held_one_inc");

    // simultaneous presses: mode wins
    press(1, 1, DB + 4);
    expect_now("simul_set_sec");
    press(1, 0, DB + 4);
    press(1, 0, DB + 4);
    press(1, 1, DB + 4);
    expect_now("simul_normal");

    // reset mid-debounce, released during reset: no pulse afterwards
    btn_mode = 1'b1;
    repeat (3) step(0);
    btn_mode = 1'b0;
    do_reset();
    repeat (20) step(0);
    expect_now("no_pulse_after_reset");

    // button held through reset release counts as a fresh press
    btn_mode = 1'b1;
    repeat (2) step(0);
    do_reset();
    for (int i = 1; i <= DB + 4; i++) begin
      step((i == DB + 4) ? 1 : 0);
      if (i == DB + 3) expect_now("held_reset_before");
    end
    expect_now("held_reset_press");
    btn_mode = 1'b0;
    repeat (DB + 4) step(0);
    expect_now("held_reset_settled");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
